// File: rtl/pdm_cic_decimator.sv
// Stereo PDM receiver with a 3rd-order CIC decimator per channel.
// Channel 0 samples on pdm_clk rising edges, channel 1 on falling edges; one PCM pair per DEC periods.
module pdm_cic_decimator #(
  parameter int DEC   = 64,
  parameter int OUT_W = 2 + 3 * $clog2(DEC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pdm_clk,
  input  logic                    pdm_data,
  output logic signed [OUT_W-1:0] out_ch0,
  output logic signed [OUT_W-1:0] out_ch1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    ovr_clr
);

  localparam int CNT_W = $clog2(DEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMB,
    S_PUSH
  } state_t;

  // PDM bit to +1 / -1 at full CIC width.
  function automatic logic signed [OUT_W-1:0] pdm_to_pcm(input logic b);
    logic signed [OUT_W-1:0] v;
    v = b ? {{(OUT_W-1){1'b0}}, 1'b1} : {OUT_W{1'b1}};
    return v;
  endfunction

  // Input synchronisers; data_d1 is aligned with clk_d1, the cycle the edge is detected.
  logic pclk_d1_q, pclk_d2_q;
  logic pdat_d1_q;
  logic rise, fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_d1_q <= 1'b0;
      pclk_d2_q <= 1'b0;
      pdat_d1_q <= 1'b0;
    end else begin
      pclk_d1_q <= pdm_clk;
      pclk_d2_q <= pclk_d1_q;
      pdat_d1_q <= pdm_data;
    end
  end

  assign rise = pclk_d1_q & ~pclk_d2_q;
  assign fall = ~pclk_d1_q & pclk_d2_q;

  logic signed [OUT_W-1:0] x_smp;
  assign x_smp = pdm_to_pcm(pdat_d1_q);

  // Integrators: arithmetic wraps modulo 2^OUT_W, which the combs undo exactly.
  logic signed [OUT_W-1:0] i0_1_q, i0_2_q, i0_3_q;
  logic signed [OUT_W-1:0] i1_1_q, i1_2_q, i1_3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i0_1_q <= '0;
      i0_2_q <= '0;
      i0_3_q <= '0;
    end else if (rise) begin
      i0_1_q <= i0_1_q + x_smp;
      i0_2_q <= i0_2_q + i0_1_q;
      i0_3_q <= i0_3_q + i0_2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1_1_q <= '0;
      i1_2_q <= '0;
      i1_3_q <= '0;
    end else if (fall) begin
      i1_1_q <= i1_1_q + x_smp;
      i1_2_q <= i1_2_q + i1_1_q;
      i1_3_q <= i1_3_q + i1_2_q;
    end
  end

  // Decimation counter runs on channel-1 (falling-edge) events.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap  = fall && (cnt_q == CNT_W'(DEC - 1));
  assign cnt_d = fall ? (cnt_q + CNT_W'(1)) : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  state_t state_q, state_d;
  logic   comb_en, push_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    comb_en = 1'b0;
    push_en = 1'b0;
    case (state_q)
      S_IDLE: if (wrap) state_d = S_COMB;
      S_COMB: begin
        comb_en = 1'b1;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        push_en = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Comb section at the decimated rate: three first differences with unit delay.
  logic signed [OUT_W-1:0] dl0_1_q, dl0_2_q, dl0_3_q, res0_q;
  logic signed [OUT_W-1:0] dl1_1_q, dl1_2_q, dl1_3_q, res1_q;
  logic signed [OUT_W-1:0] c0_1, c0_2, c0_3;
  logic signed [OUT_W-1:0] c1_1, c1_2, c1_3;

  assign c0_1 = i0_3_q - dl0_1_q;
  assign c0_2 = c0_1 - dl0_2_q;
  assign c0_3 = c0_2 - dl0_3_q;
  assign c1_1 = i1_3_q - dl1_1_q;
  assign c1_2 = c1_1 - dl1_2_q;
  assign c1_3 = c1_2 - dl1_3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl0_1_q <= '0;
      dl0_2_q <= '0;
      dl0_3_q <= '0;
      res0_q  <= '0;
      dl1_1_q <= '0;
      dl1_2_q <= '0;
      dl1_3_q <= '0;
      res1_q  <= '0;
    end else if (comb_en) begin
      dl0_1_q <= i0_3_q;
      dl0_2_q <= c0_1;
      dl0_3_q <= c0_2;
      res0_q  <= c0_3;
      dl1_1_q <= i1_3_q;
      dl1_2_q <= c1_1;
      dl1_3_q <= c1_2;
      res1_q  <= c1_3;
    end
  end

  // Output register, handshake and overrun; the first three pairs are comb warm-up.
  logic [1:0]              settle_q, settle_d;
  logic                    vld_q, vld_d;
  logic                    ovr_q, ovr_d;
  logic signed [OUT_W-1:0] out0_q, out1_q;
  logic                    keep, pending;

  assign keep     = push_en && (settle_q == 2'd3);
  assign pending  = vld_q && !out_ready;
  assign settle_d = (push_en && (settle_q != 2'd3)) ? (settle_q + 2'd1) : settle_q;
  assign vld_d    = keep ? 1'b1 : pending;
  assign ovr_d    = (keep && pending) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      vld_q    <= 1'b0;
      ovr_q    <= 1'b0;
      out0_q   <= '0;
      out1_q   <= '0;
    end else begin
      settle_q <= settle_d;
      vld_q    <= vld_d;
      ovr_q    <= ovr_d;
      if (keep) begin
        out0_q <= res0_q;
        out1_q <= res1_q;
      end
    end
  end

  assign out_ch0   = out0_q;
  assign out_ch1   = out1_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Scoreboard bench for pdm_cic_decimator: directed PDM patterns, expected pairs queued by the
// stimulus and popped by a monitor on every accepted output.
module tb_pdm_cic_decimator;

  localparam int DEC  = 64;
  localparam int W    = 20;
  localparam int HALF = 4;
  localparam int FULL = DEC * DEC * DEC;

  logic                clk;
  logic                rst;
  logic                pdm_clk;
  logic                pdm_data;
  logic signed [W-1:0] out_ch0;
  logic signed [W-1:0] out_ch1;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;
  logic                ovr_clr;

  pdm_cic_decimator #(.DEC(DEC)) dut (
    .clk      (clk),
    .rst      (rst),
    .pdm_clk  (pdm_clk),
    .pdm_data (pdm_data),
    .out_ch0  (out_ch0),
    .out_ch1  (out_ch1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   falls    = 0;
  int   fall256_cyc = 0;
  int   mode     = 0;
  logic alt      = 1'b1;
  int   hs_q[$];
  int   exp0_q[$];
  int   exp1_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    int e0, e1;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        hs_q.push_back(cyc);
        if (exp0_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pair: got ch0=%0d ch1=%0d expected no pair", out_ch0, out_ch1);
        end else begin
          e0 = exp0_q.pop_front();
          e1 = exp1_q.pop_front();
          chk("pair_ch0", int'(out_ch0), e0);
          chk("pair_ch1", int'(out_ch1), e1);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl);
    pdm_clk = lvl;
    case (mode)
      0:       pdm_data = 1'b1;
      1:       pdm_data = 1'b0;
      2:       pdm_data = lvl;
      3:       pdm_data = alt;
      default: pdm_data = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Full pdm_clk periods, starting high; counts falls and notes when the 256th was driven.
  task automatic run_periods(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1);
      wait_clks(HALF);
      drive(1'b0);
      falls++;
      if (falls == 256) fall256_cyc = cyc;
      wait_clks(HALF);
      alt = ~alt;
    end
  endtask

  task automatic push_exp(input int a, input int b);
    exp0_q.push_back(a);
    exp1_q.push_back(b);
  endtask

  task automatic do_reset();
    pdm_clk = 1'b0;
    rst     = 1'b0;
    wait_clks(3);
    rst   = 1'b1;
    falls = 0;
    alt   = 1'b1;
    hs_q.delete();
  endtask

  // Latency from driving the pin: 2 synchroniser clocks plus the 2 clocks after the fall event.
  initial begin
    rst = 1'b0; pdm_clk = 1'b0; pdm_data = 1'b0;
    out_ready = 1'b1; ovr_clr = 1'b0;
    wait_clks(2);

    mode = 4;
    run_periods(20);
    chk("t1_rst_ch0", int'(out_ch0), 0);
    chk("t1_rst_ch1", int'(out_ch1), 0);
    chk("t1_rst_valid", int'(out_valid), 0);
    chk("t1_rst_overrun", int'(overrun), 0);
    rst = 1'b1; falls = 0; hs_q.delete();
    run_periods(255);
    chk("t1_no_early_pair", hs_q.size(), 0);

    mode = 0;
    do_reset();
    repeat (3) push_exp(FULL, FULL);
    run_periods(386);
    chk("t2_pair_count", hs_q.size(), 3);
    if (hs_q.size() >= 3) begin
      chk("t2_latency", hs_q[0] - fall256_cyc, 2 + 2);
      chk("t2_interval1", hs_q[1] - hs_q[0], DEC * 2 * HALF);
      chk("t2_interval2", hs_q[2] - hs_q[1], DEC * 2 * HALF);
    end
    chk("t2_overrun", int'(overrun), 0);
    chk("t2_queue_empty", exp0_q.size(), 0);

    mode = 1;
    do_reset();
    repeat (2) push_exp(-FULL, -FULL);
    run_periods(322);
    chk("t3_queue_empty", exp0_q.size(), 0);

    mode = 2;
    do_reset();
    repeat (2) push_exp(FULL, -FULL);
    run_periods(322);
    chk("t4a_queue_empty", exp0_q.size(), 0);

    mode = 3;
    do_reset();
    repeat (2) push_exp(0, 0);
    run_periods(322);
    chk("t4b_queue_empty", exp0_q.size(), 0);

    mode = 0;
    out_ready = 1'b0;
    do_reset();
    push_exp(FULL, FULL);
    run_periods(258);
    chk("t5_first_valid", int'(out_valid), 1);
    chk("t5_first_no_overrun", int'(overrun), 0);
    chk("t5_first_ch0", int'(out_ch0), FULL);
    run_periods(64);
    chk("t5_overrun_set", int'(overrun), 1);
    chk("t5_still_valid", int'(out_valid), 1);
    chk("t5_second_ch0", int'(out_ch0), FULL);
    chk("t5_second_ch1", int'(out_ch1), FULL);
    ovr_clr = 1'b1;
    wait_clks(1);
    ovr_clr = 1'b0;
    chk("t5_overrun_cleared", int'(overrun), 0);
    chk("t5_valid_after_clr", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_clks(2);
    chk("t5_valid_dropped", int'(out_valid), 0);
    chk("t5_queue_empty", exp0_q.size(), 0);

    mode = 0;
    do_reset();
    push_exp(FULL, FULL);
    run_periods(4 * 64 + 30);
    chk("t6_held_ch0", int'(out_ch0), FULL);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_ch0", int'(out_ch0), 0);
    chk("t6_async_ch1", int'(out_ch1), 0);
    chk("t6_async_valid", int'(out_valid), 0);
    wait_clks(3);
    rst = 1'b1; falls = 0; alt = 1'b1;
    hs_q.delete();
    push_exp(FULL, FULL);
    run_periods(258);
    chk("t6_pair_count", hs_q.size(), 1);
    if (hs_q.size() >= 1) chk("t6_latency", hs_q[0] - fall256_cyc, 2 + 2);
    chk("t6_queue_empty", exp0_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
